// File: rtl/alu_block_param_if.sv
// Control/status bundle between the control decoder and the ALU block.
// Latency: none (wires only). Backpressure: busy tells the master to hold off new starts/loads.
// Ports: outctl/loadctl/arg_l/arg_r/op/cin/calcfn/start from master; busy/fout from slave.
interface alu_block_param_if #(
  parameter int SELW = 2
);
  logic [3:0]      outctl;
  logic [3:0]      loadctl;
  logic [SELW-1:0] arg_l;
  logic [SELW-1:0] arg_r;
  logic [3:0]      op;
  logic            cin;
  logic            calcfn;
  logic            start;
  logic            busy;
  logic [3:0]      fout;

  modport master (
    output outctl, loadctl, arg_l, arg_r, op, cin, calcfn, start,
    input  busy, fout
  );

  modport slave (
    input  outctl, loadctl, arg_l, arg_r, op, cin, calcfn, start,
    output busy, fout
  );
endinterface

// File: rtl/alu_block_param.sv
// Parametrised ALU block: NREGS bus-loadable operand registers, flags, single-cycle ALU, shift-add MUL.
// Latency: ALU result is combinational onto main_bus; MUL (and DIV with ALU_DIV_EN) takes WIDTH+1 cycles.
// Backpressure: busy=1 while a multi-cycle op runs; start and register/flag loads are ignored then.
// Ports: clk, rst (sync, active-high), main_bus (shared tri-state bus), ctl (alu_block_param_if.slave).
// Optional macro ALU_DIV_EN: op 9 + start runs a restoring divider through the same FSM.
module alu_block_param #(
  parameter int WIDTH = 8,
  parameter int NREGS = 4,
  parameter int SELW  = 2
) (
  input  logic              clk,
  input  logic              rst,
  inout  wire [WIDTH-1:0]   main_bus,
  alu_block_param_if.slave  ctl
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_t;

  logic [WIDTH-1:0]   regs_q [NREGS];
  logic [3:0]         fout_q;
  state_t             state_q;
  logic               busy_q;
  logic [CW-1:0]      cnt_q;
  logic [2*WIDTH-1:0] acc_q;     // {high/remainder, low/quotient}
  logic [WIDTH-1:0]   opnd_q;    // multiplicand or divisor
  logic               is_div_q;
  logic               calc_q;
  logic               div0_q;
  logic [SELW-1:0]    dst_q;

  // Operand fetch; indices beyond NREGS (non power-of-two NREGS) read as zero.
  logic [WIDTH-1:0] opl, opr;
  always_comb begin
    opl = '0;
    opr = '0;
    if (int'(ctl.arg_l) < NREGS) opl = regs_q[ctl.arg_l];
    if (int'(ctl.arg_r) < NREGS) opr = regs_q[ctl.arg_r];
  end

  // Single-cycle ALU
  logic [WIDTH-1:0] opr_eff;
  logic [WIDTH:0]   sum_w;
  logic [WIDTH-1:0] alu_res;
  logic             alu_c, alu_v;
  logic [3:0]       alu_flags;

  always_comb begin
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    // SUB is L + ~R + cin, so the adder is shared and C=1 means no borrow.
    opr_eff = (ctl.op == 4'd1) ? ~opr : opr;
    sum_w   = {1'b0, opl} + {1'b0, opr_eff} + {{WIDTH{1'b0}}, ctl.cin};
    case (ctl.op)
      4'd0, 4'd1: begin
        alu_res = sum_w[WIDTH-1:0];
        alu_c   = sum_w[WIDTH];
        alu_v   = (opl[WIDTH-1] == opr_eff[WIDTH-1]) && (sum_w[WIDTH-1] != opl[WIDTH-1]);
      end
      4'd2: alu_res = opl & opr;
      4'd3: alu_res = opl | opr;
      4'd4: alu_res = opl ^ opr;
      4'd5: begin
        alu_res = {opl[WIDTH-2:0], 1'b0};
        alu_c   = opl[WIDTH-1];
      end
      4'd6: begin
        alu_res = {1'b0, opl[WIDTH-1:1]};
        alu_c   = opl[0];
      end
      4'd7: alu_res = opl;
      default: alu_res = '0;
    endcase
    alu_flags = {alu_res[WIDTH-1], (alu_res == '0), alu_c, alu_v};
  end

  // Bus output select
  logic             drv_en;
  logic [WIDTH-1:0] drv_dat;

  always_comb begin
    drv_en  = 1'b0;
    drv_dat = '0;
    if (int'(ctl.outctl) < NREGS) begin
      drv_en  = 1'b1;
      drv_dat = regs_q[ctl.outctl[SELW-1:0]];
    end else if (ctl.outctl == 4'd13) begin
      drv_en  = 1'b1;
      drv_dat = alu_res;
    end else if (ctl.outctl == 4'd14) begin
      drv_en  = 1'b1;
      drv_dat = {{(WIDTH-4){1'b0}}, fout_q};
    end
  end

  assign main_bus = drv_en ? drv_dat : {WIDTH{1'bz}};
  assign ctl.busy = busy_q;
  assign ctl.fout = fout_q;

  // Multi-cycle op acceptance
  logic op_div;
`ifdef ALU_DIV_EN
  assign op_div = (ctl.op == 4'd9);
`else
  assign op_div = 1'b0;
`endif

  logic start_ok;
  assign start_ok = ctl.start && (state_q == ST_IDLE) && ((ctl.op == 4'd8) || op_div);

  // Shift-add multiply step: conditionally add multiplicand to the high half, then shift right.
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;
  // Restoring divide step: shift {rem,quo} left, subtract divisor if it fits.
  logic [WIDTH:0]     div_sh, div_diff;
  logic               div_ge;
  logic [2*WIDTH-1:0] div_next;
  logic [3:0]         done_flags;
  logic [SELW-1:0]    dst_hi;

  always_comb begin
    mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : {(WIDTH+1){1'b0}});
    mul_next = {mul_sum, acc_q[WIDTH-1:1]};
    div_sh   = acc_q[2*WIDTH-1:WIDTH-1];
    div_ge   = (div_sh >= {1'b0, opnd_q});
    div_diff = div_sh - {1'b0, opnd_q};
    // A zero divisor always "fits", giving all-ones quotient and remainder = dividend.
    div_next = {(div_ge ? div_diff[WIDTH-1:0] : div_sh[WIDTH-1:0]), acc_q[WIDTH-2:0], div_ge};
    if (is_div_q)
      done_flags = {acc_q[WIDTH-1], (acc_q[WIDTH-1:0] == '0), 1'b0, div0_q};
    else
      done_flags = {acc_q[2*WIDTH-1], (acc_q == '0), (acc_q[2*WIDTH-1:WIDTH] != '0), 1'b0};
    dst_hi = (int'(dst_q) == NREGS - 1) ? '0 : dst_q + SELW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < NREGS; k++) regs_q[k] <= '0;
      fout_q   <= '0;
      state_q  <= ST_IDLE;
      busy_q   <= 1'b0;
      cnt_q    <= '0;
      acc_q    <= '0;
      opnd_q   <= '0;
      is_div_q <= 1'b0;
      calc_q   <= 1'b0;
      div0_q   <= 1'b0;
      dst_q    <= '0;
    end else begin
      // Bus loads sample main_bus pre-edge, so self-load of the ALU result accumulates.
      if (!busy_q && (int'(ctl.loadctl) < NREGS))
        regs_q[ctl.loadctl[SELW-1:0]] <= main_bus;

      if (!busy_q && (ctl.loadctl == 4'd14))
        fout_q <= main_bus[3:0];
      else if (ctl.calcfn && (ctl.outctl == 4'd13) && (ctl.op <= 4'd7))
        fout_q <= alu_flags;

      case (state_q)
        ST_IDLE: begin
          if (start_ok) begin
            state_q  <= ST_RUN;
            busy_q   <= 1'b1;
            cnt_q    <= '0;
            is_div_q <= op_div;
            calc_q   <= ctl.calcfn;
            dst_q    <= ctl.arg_l;
            div0_q   <= (opr == '0);
            if (op_div) begin
              acc_q  <= {{WIDTH{1'b0}}, opl};
              opnd_q <= opr;
            end else begin
              acc_q  <= {{WIDTH{1'b0}}, opr};
              opnd_q <= opl;
            end
          end
        end
        ST_RUN: begin
          acc_q <= is_div_q ? div_next : mul_next;
          cnt_q <= cnt_q + CW'(1);
          if (cnt_q == CW'(WIDTH - 1)) state_q <= ST_DONE;
        end
        ST_DONE: begin
          // Placed after the load logic so write-back and its flags take priority.
          regs_q[dst_q]  <= acc_q[WIDTH-1:0];
          regs_q[dst_hi] <= acc_q[2*WIDTH-1:WIDTH];
          if (calc_q) fout_q <= done_flags;
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_block_param.sv
// Directed bench for alu_block_param: 8-bit/4-reg instance plus a 16-bit/8-reg instance.
// Latency: n/a. Backpressure: n/a.
// Vector table for single-cycle ops, hand sequences for MUL/DIV, busy and reset corners.
module tb_alu_block_param;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  wire  [7:0]  bus8;
  logic        tb8_en;
  logic [7:0]  tb8_dat;
  assign bus8 = tb8_en ? tb8_dat : 8'bz;

  wire  [15:0] bus16;
  logic        tb16_en;
  logic [15:0] tb16_dat;
  assign bus16 = tb16_en ? tb16_dat : 16'bz;

  alu_block_param_if #(.SELW(2)) ifc8 ();
  alu_block_param_if #(.SELW(3)) ifc16 ();

  alu_block_param #(.WIDTH(8), .NREGS(4), .SELW(2)) u8 (
    .clk(clk), .rst(rst), .main_bus(bus8), .ctl(ifc8)
  );
  alu_block_param #(.WIDTH(16), .NREGS(8), .SELW(3)) u16 (
    .clk(clk), .rst(rst), .main_bus(bus16), .ctl(ifc16)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load8(input logic [3:0] k, input logic [7:0] v);
    tb8_dat = v; tb8_en = 1'b1; ifc8.outctl = 4'd15; ifc8.loadctl = k;
    step();
    tb8_en = 1'b0; ifc8.loadctl = 4'd15;
  endtask

  task automatic rd8(input logic [3:0] k, output logic [7:0] v);
    tb8_en = 1'b0; ifc8.outctl = k;
    #1 v = bus8;
    ifc8.outctl = 4'd15;
  endtask

  task automatic load16(input logic [3:0] k, input logic [15:0] v);
    tb16_dat = v; tb16_en = 1'b1; ifc16.outctl = 4'd15; ifc16.loadctl = k;
    step();
    tb16_en = 1'b0; ifc16.loadctl = 4'd15;
  endtask

  task automatic rd16(input logic [3:0] k, output logic [15:0] v);
    tb16_en = 1'b0; ifc16.outctl = k;
    #1 v = bus16;
    ifc16.outctl = 4'd15;
  endtask

  // Pulse start and count busy cycles; optionally disturb with a start and a load mid-run.
  task automatic run8(input logic [1:0] al, input logic [1:0] ar, input logic [3:0] opv,
                      input bit disturb, input logic [7:0] pre, output int cyc);
    logic [7:0] v;
    ifc8.arg_l = al; ifc8.arg_r = ar; ifc8.op = opv; ifc8.calcfn = 1'b1; ifc8.start = 1'b1;
    step();
    ifc8.start = 1'b0; ifc8.calcfn = 1'b0;
    cyc = 0;
    while (ifc8.busy && cyc < 64) begin
      cyc++;
      if (disturb && cyc == 3) begin
        ifc8.start = 1'b1; ifc8.op = 4'd8; ifc8.arg_l = 2'd0;
        tb8_dat = 8'h55; tb8_en = 1'b1; ifc8.loadctl = 4'd2;
      end
      step();
      if (disturb && cyc == 3) begin
        ifc8.start = 1'b0; tb8_en = 1'b0; ifc8.loadctl = 4'd15; ifc8.arg_l = al;
        rd8({2'b00, al}, v);
        chk("busy_read_prewb", {24'd0, v}, {24'd0, pre});
      end
    end
    ifc8.op = 4'd0;
  endtask

  task automatic run16(input logic [2:0] al, input logic [2:0] ar, input logic [3:0] opv,
                       output int cyc);
    ifc16.arg_l = al; ifc16.arg_r = ar; ifc16.op = opv; ifc16.calcfn = 1'b1; ifc16.start = 1'b1;
    step();
    ifc16.start = 1'b0; ifc16.calcfn = 1'b0;
    cyc = 0;
    while (ifc16.busy && cyc < 64) begin
      cyc++;
      step();
    end
    ifc16.op = 4'd0;
  endtask

  typedef struct {
    logic [7:0] l;
    logic [7:0] r;
    logic       cin;
    logic [3:0] op;
    logic [7:0] res;
    logic [3:0] fl;
  } vec_t;

  vec_t vecs[16];

  initial begin
    logic [7:0]  v8;
    logic [15:0] v16;
    int          cyc;

    vecs[0]  = '{8'd24,  8'd18,  1'b0, 4'd0,  8'd42,  4'b0000};
    vecs[1]  = '{8'd42,  8'd214, 1'b0, 4'd0,  8'd0,   4'b0110};
    vecs[2]  = '{8'd5,   8'd7,   1'b1, 4'd1,  8'd254, 4'b1000};
    vecs[3]  = '{8'h7F,  8'h01,  1'b0, 4'd0,  8'h80,  4'b1001};
    vecs[4]  = '{8'h80,  8'h01,  1'b1, 4'd1,  8'h7F,  4'b0011};
    vecs[5]  = '{8'hF0,  8'h3C,  1'b0, 4'd2,  8'h30,  4'b0000};
    vecs[6]  = '{8'h00,  8'h00,  1'b0, 4'd3,  8'h00,  4'b0100};
    vecs[7]  = '{8'hAA,  8'h55,  1'b0, 4'd4,  8'hFF,  4'b1000};
    vecs[8]  = '{8'h81,  8'h00,  1'b0, 4'd5,  8'h02,  4'b0010};
    vecs[9]  = '{8'h01,  8'h00,  1'b0, 4'd6,  8'h00,  4'b0110};
    vecs[10] = '{8'h80,  8'h00,  1'b0, 4'd7,  8'h80,  4'b1000};
    vecs[11] = '{8'd3,   8'd4,   1'b0, 4'd8,  8'h00,  4'b1000};
    vecs[12] = '{8'd3,   8'd4,   1'b0, 4'd9,  8'h00,  4'b1000};
    vecs[13] = '{8'd3,   8'd4,   1'b0, 4'd12, 8'h00,  4'b1000};
    vecs[14] = '{8'd3,   8'd3,   1'b1, 4'd1,  8'h00,  4'b0110};
    vecs[15] = '{8'h80,  8'h80,  1'b0, 4'd0,  8'h00,  4'b0111};

    tb8_en = 1'b0; tb8_dat = '0; tb16_en = 1'b0; tb16_dat = '0;
    ifc8.outctl = 4'd15; ifc8.loadctl = 4'd15; ifc8.arg_l = '0; ifc8.arg_r = '0;
    ifc8.op = '0; ifc8.cin = 1'b0; ifc8.calcfn = 1'b0; ifc8.start = 1'b0;
    ifc16.outctl = 4'd15; ifc16.loadctl = 4'd15; ifc16.arg_l = '0; ifc16.arg_r = '0;
    ifc16.op = '0; ifc16.cin = 1'b0; ifc16.calcfn = 1'b0; ifc16.start = 1'b0;

    rst = 1'b1;
    step(); step();
    rst = 1'b0;

    // Reset state
    chk("rst_busy", {31'd0, ifc8.busy}, 32'd0);
    chk("rst_fout", {28'd0, ifc8.fout}, 32'd0);
    for (int k = 0; k < 4; k++) begin
      rd8(4'(k), v8);
      chk($sformatf("rst_R%0d", k), {24'd0, v8}, 32'd0);
    end
    rd8(4'd14, v8);
    chk("rst_flagread", {24'd0, v8}, 32'd0);
    chk("rst_busy16", {31'd0, ifc16.busy}, 32'd0);

    // Single-cycle ALU vectors, each self-loading the result into R0
    for (int i = 0; i < 16; i++) begin
      load8(4'd0, vecs[i].l);
      load8(4'd1, vecs[i].r);
      ifc8.arg_l = 2'd0; ifc8.arg_r = 2'd1; ifc8.op = vecs[i].op; ifc8.cin = vecs[i].cin;
      ifc8.calcfn = 1'b1; ifc8.outctl = 4'd13; ifc8.loadctl = 4'd0;
      #1;
      chk($sformatf("vec%0d_result", i), {24'd0, bus8}, {24'd0, vecs[i].res});
      step();
      ifc8.outctl = 4'd15; ifc8.loadctl = 4'd15; ifc8.calcfn = 1'b0; ifc8.cin = 1'b0;
      chk($sformatf("vec%0d_flags", i), {28'd0, ifc8.fout}, {28'd0, vecs[i].fl});
      rd8(4'd0, v8);
      chk($sformatf("vec%0d_selfload", i), {24'd0, v8}, {24'd0, vecs[i].res});
    end

    // loadctl=14 beats the calcfn update: 24+18=0x2A, low nibble lands in fout
    load8(4'd0, 8'd24);
    load8(4'd1, 8'd18);
    ifc8.op = 4'd0; ifc8.calcfn = 1'b1; ifc8.outctl = 4'd13; ifc8.loadctl = 4'd14;
    step();
    ifc8.outctl = 4'd15; ifc8.loadctl = 4'd15; ifc8.calcfn = 1'b0;
    chk("flagload_wins", {28'd0, ifc8.fout}, 32'hA);
    rd8(4'd14, v8);
    chk("flag_busread", {24'd0, v8}, 32'h0A);

    // start with a non-multicycle op is ignored
    ifc8.op = 4'd7; ifc8.start = 1'b1;
    step();
    ifc8.start = 1'b0;
    chk("start_op7_ignored", {31'd0, ifc8.busy}, 32'd0);
`ifndef ALU_DIV_EN
    ifc8.op = 4'd9; ifc8.start = 1'b1;
    step();
    ifc8.start = 1'b0;
    chk("start_op9_ignored", {31'd0, ifc8.busy}, 32'd0);
`endif
    ifc8.op = 4'd0;

    // MUL 13*21 = 0x111, with a start and a load attempted while busy
    load8(4'd2, 8'd13);
    load8(4'd3, 8'd21);
    run8(2'd2, 2'd3, 4'd8, 1'b1, 8'd13, cyc);
    chk("mul_busy_cycles", cyc, 32'd9);
    rd8(4'd2, v8);
    chk("mul_lo_R2", {24'd0, v8}, 32'h11);
    rd8(4'd3, v8);
    chk("mul_hi_R3", {24'd0, v8}, 32'h01);
    chk("mul_flags", {28'd0, ifc8.fout}, 32'b0010);
    rd8(4'd0, v8);
    chk("mul_R0_untouched", {24'd0, v8}, 32'd24);

    // Reset in RUN cycle 4 aborts with no write-back
    ifc8.arg_l = 2'd2; ifc8.arg_r = 2'd3; ifc8.op = 4'd8; ifc8.calcfn = 1'b1; ifc8.start = 1'b1;
    step();
    ifc8.start = 1'b0; ifc8.calcfn = 1'b0;
    repeat (3) step();
    chk("pre_rst_busy", {31'd0, ifc8.busy}, 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("abort_busy", {31'd0, ifc8.busy}, 32'd0);
    chk("abort_fout", {28'd0, ifc8.fout}, 32'd0);
    for (int k = 0; k < 4; k++) begin
      rd8(4'(k), v8);
      chk($sformatf("abort_R%0d", k), {24'd0, v8}, 32'd0);
    end
    repeat (12) step();
    rd8(4'd2, v8);
    chk("abort_no_late_wb", {24'd0, v8}, 32'd0);

    // Fresh MUL after abort: 16*16 = 0x100
    load8(4'd0, 8'd16);
    load8(4'd1, 8'd16);
    run8(2'd0, 2'd1, 4'd8, 1'b0, 8'd0, cyc);
    chk("mul2_busy_cycles", cyc, 32'd9);
    rd8(4'd0, v8);
    chk("mul2_lo_R0", {24'd0, v8}, 32'h00);
    rd8(4'd1, v8);
    chk("mul2_hi_R1", {24'd0, v8}, 32'h01);
    chk("mul2_flags", {28'd0, ifc8.fout}, 32'b0010);

    // 16-bit instance: 0xFFFF*0xFFFF into R7, high half wraps into R0
    load16(4'd7, 16'hFFFF);
    run16(3'd7, 3'd7, 4'd8, cyc);
    chk("mul16_busy_cycles", cyc, 32'd17);
    rd16(4'd7, v16);
    chk("mul16_lo_R7", {16'd0, v16}, 32'h0001);
    rd16(4'd0, v16);
    chk("mul16_hi_R0", {16'd0, v16}, 32'hFFFE);
    chk("mul16_flags", {28'd0, ifc16.fout}, 32'b1010);

`ifdef ALU_DIV_EN
    load16(4'd1, 16'd100);
    load16(4'd2, 16'd7);
    run16(3'd1, 3'd2, 4'd9, cyc);
    chk("div_busy_cycles", cyc, 32'd17);
    rd16(4'd1, v16);
    chk("div_quot", {16'd0, v16}, 32'd14);
    rd16(4'd2, v16);
    chk("div_rem", {16'd0, v16}, 32'd2);
    chk("div_flags_zcv", {29'd0, ifc16.fout[2:0]}, 32'd0);
    load16(4'd3, 16'd5);
    load16(4'd4, 16'd0);
    run16(3'd3, 3'd4, 4'd9, cyc);
    rd16(4'd3, v16);
    chk("div0_quot", {16'd0, v16}, 32'hFFFF);
    rd16(4'd4, v16);
    chk("div0_rem", {16'd0, v16}, 32'd5);
    chk("div0_V", {31'd0, ifc16.fout[0]}, 32'd1);
`else
    ifc16.op = 4'd9; ifc16.start = 1'b1;
    step();
    ifc16.start = 1'b0; ifc16.op = 4'd0;
    chk("start16_op9_ignored", {31'd0, ifc16.busy}, 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/alu_block_param.md
Name: alu_block_param

Overview:
Parametrised successor to the CPU's ALU block.
- Holds NREGS bus-loadable operand registers and a 4-bit flags register.
- Computes single-cycle ALU ops combinationally onto the shared tri-state main bus.
- Adds a multi-cycle shift-add multiplier with busy handshake.
- Sits on main_bus beside the other register/control blocks; driven by the control decoder's outctl/loadctl fields.

Parameters:
- WIDTH, 8: data/bus width in bits (4..32).
- NREGS, 4: number of operand registers (2..12).
- SELW, 2: register-select width; must equal clog2(NREGS).

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  synchronous active-high reset.
- main_bus  inout  WIDTH  shared data bus.
- outctl  in  4  bus output select; 15 = none.
- loadctl  in  4  register load select; 15 = none.
- arg_l  in  SELW  left operand register index.
- arg_r  in  SELW  right operand register index.
- op  in  4  operation code.
- cin  in  1  carry-in for ADD/SUB.
- calcfn  in  1  flags update enable.
- start  in  1  start multi-cycle op (single-cycle pulse).
- busy  out  1  multi-cycle op in progress.
- fout  out  4  flags {N,Z,C,V}: N=bit3, Z=bit2, C=bit1, V=bit0.

Behaviour:
- Reset: all R[k]=0, fout=0, busy=0, FSM=IDLE, main_bus high-Z. Reset mid-operation aborts the multiply with no write-back.
- Bus output (combinational):
  - outctl k<NREGS drives R[k].
  - outctl 13 drives ALU result.
  - outctl 14 drives {0…,fout}.
  - Other values: high-Z.
- Loads, on the clk edge:
  - loadctl k<NREGS: R[k] <= main_bus.
  - loadctl 14: fout <= main_bus[3:0].
  - Other values: no load.
- ALU ops, L=R[arg_l], R=R[arg_r], results truncated to WIDTH:
  - 0 ADD: L+R+cin.
  - 1 SUB: L+~R+cin; C=1 means no borrow.
  - 2 AND, 3 OR, 4 XOR.
  - 5 SHL: L<<1, C=old msb.
  - 6 SHR (logical): C=old lsb.
  - 7 PASS: L.
  - 8 MUL: multi-cycle; combinational result 0.
  - 9 DIV: see optional feature.
  - 10..15: result 0, no flag update.
- Flags:
  - Z = (result==0); N = result msb.
  - C = carry-out for ADD/SUB/shifts; 0 for logic/PASS.
  - V = signed overflow for ADD/SUB; 0 otherwise.
  - fout updates on the edge when calcfn=1 and outctl=13 and op<=7.
  - A simultaneous loadctl=14 wins over the calcfn update.
- Self-load: outctl=13 with loadctl=arg_l is legal. The register takes the pre-edge result (e.g. accumulate into R[0]).
- MUL FSM, states IDLE -> RUN -> DONE -> IDLE:
  - IDLE -> RUN when start=1 and op=8. Operands are latched at that edge; calcfn is latched too.
  - RUN lasts exactly WIDTH cycles, one shift-add step per cycle.
  - DONE lasts one cycle. Its closing edge writes R[arg_l_latched] <= product low half and R[(arg_l_latched+1) mod NREGS] <= high half.
  - Flags at DONE, only if calcfn was latched: Z = (full product==0), C = (high half!=0), N = high-half msb, V=0.
  - busy=1 throughout RUN and DONE, i.e. WIDTH+1 cycles. It drops the cycle after write-back.
- While busy:
  - start is ignored.
  - loadctl values <NREGS and 14 are ignored.
  - outctl remains functional and reads pre-write-back register values.
- start with op≠8 (and op≠9 when enabled) is ignored.

Optional Feature:
- Macro ALU_DIV_EN.
- Defined: op 9 with start runs a restoring divider through the same FSM (WIDTH RUN cycles + DONE).
  - Write-back: quotient to R[arg_l], remainder to R[arg_l+1 mod NREGS].
  - Divide by zero: quotient all-ones, remainder = dividend, V=1.
  - Otherwise V=0; Z = quotient==0; C=0.
- Undefined: op 9 behaves as opcodes 10..15 (result 0, no flag update). start with op 9 is ignored and busy stays 0.

Test Plan:
1. Load R0=24, R1=18; ADD arg_l=0, arg_r=1, outctl=13, loadctl=0, calcfn=1 -> R0=42, fout=4'b0000.
2. R0=42, R1=214; ADD into R0 -> R0=0, fout=4'b0110 (Z,C).
3. R0=5, R1=7, cin=1; SUB -> result 254, fout=4'b1000 (N set, C=0 borrow). Then R0=0x7F, R1=0x01, ADD cin=0 -> 0x80, fout=4'b1001.
4. R2=13, R3=21; pulse start with op=8, arg_l=2, arg_r=3, calcfn=1 -> busy high exactly 9 cycles. Then R2=0x11, R3=0x01, fout=4'b0010. A second start during busy and loadctl=2 during busy -> no effect.
5. Start MUL, assert rst at RUN cycle 4 -> next edge busy=0, all registers 0, fout=0. A fresh start then completes normally.
6. WIDTH=16, NREGS=8 build: 0xFFFF*0xFFFF into R7 -> R7=0x0001, R0=0xFFFE (wrap of index), busy 17 cycles. Under ALU_DIV_EN: 100/7 -> quotient 14, remainder 2; 5/0 -> 0xFFFF, remainder 5, V=1.
